// File: rtl/drum_sector_reader.sv
// Receive-side decoder for the drum timing tracks: recovers word framing from
// the word-mark track, deserialises the sector address and checks continuity.
module drum_sector_reader #(
    parameter int WORD_BITS  = 40,
    parameter int ADDR_BITS  = 7,
    parameter int ADDR_FIRST = 32,
    parameter int LOCK_WORDS = 2
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 Z1,
    input  logic                 Z2,
    input  logic                 Z3,
    input  logic [ADDR_BITS-1:0] target,
    output logic [5:0]           bit_cnt,
    output logic [ADDR_BITS-1:0] sector,
    output logic                 index,
    output logic                 word_end,
    output logic                 locked,
    output logic                 match,
    output logic                 window,
    output logic                 seq_err
);

    localparam int LW = $clog2(LOCK_WORDS + 1);
    localparam logic [5:0] SYNC_BIT = 6'd31;
    localparam logic [5:0] LAST_BIT = 6'(WORD_BITS - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    logic                 r_z1_prev;
    logic                 r_z2_prev;
    logic [3:0]           r_low_run;
    logic [5:0]           r_bit_cnt;
    logic [ADDR_BITS-1:0] r_stage;
    logic [ADDR_BITS-1:0] r_sector;
    logic                 r_index;
    logic [LW-1:0]        r_lock_cnt;
    logic                 r_locked;
    logic                 r_have_prev;
    logic                 r_word_end;
    logic                 r_match;
    logic                 r_window;
    logic                 r_seq_err;

    logic                 w_be;
    logic                 w_sync;
    logic [5:0]           w_bit_inc;
    logic [5:0]           w_bit_nxt;
    logic                 w_frame_ok;
    logic                 w_frame_err;
    logic                 w_last;
    logic                 w_cont_err;
    logic                 w_match;
    logic [LW-1:0]        w_lock_inc;

    always_comb begin
        w_be        = Z1 & ~r_z1_prev;
        // A mark rising after a long low run is the sync mark; after a short run it is the secondary mark.
        w_sync      = Z2 & ~r_z2_prev & (r_low_run >= 4'd8);
        w_bit_inc   = (r_bit_cnt == LAST_BIT) ? 6'd0 : r_bit_cnt + 6'd1;
        w_bit_nxt   = w_sync ? SYNC_BIT : w_bit_inc;
        w_frame_ok  = w_be & w_sync & (w_bit_inc == SYNC_BIT);
        w_frame_err = w_be & w_sync & (w_bit_inc != SYNC_BIT);
        w_last      = w_be & (w_bit_nxt == LAST_BIT);
        w_cont_err  = w_last & r_locked & r_have_prev &
                      ((r_stage != r_sector + ADDR_ONE) | (Z3 != (r_stage == '0)));
        w_match     = w_last & r_locked & ~w_frame_err & (r_stage == target);
        w_lock_inc  = (r_lock_cnt == LW'(LOCK_WORDS)) ? r_lock_cnt : r_lock_cnt + LW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            r_z1_prev   <= 1'b0;
            r_z2_prev   <= 1'b0;
            r_low_run   <= 4'd0;
            r_bit_cnt   <= 6'd0;
            r_stage     <= '0;
            r_sector    <= '0;
            r_index     <= 1'b0;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_have_prev <= 1'b0;
            r_word_end  <= 1'b0;
            r_match     <= 1'b0;
            r_window    <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_z1_prev  <= Z1;
            r_word_end <= w_last;
            r_match    <= w_match;
            r_seq_err  <= w_frame_err | w_cont_err;

            if (w_be) begin
                r_z2_prev <= Z2;
                r_low_run <= Z2 ? 4'd0 : ((r_low_run == 4'd15) ? 4'd15 : r_low_run + 4'd1);
                r_bit_cnt <= w_bit_nxt;
                for (int i = 0; i < ADDR_BITS; i++) begin
                    if (w_bit_nxt == 6'(ADDR_FIRST + i)) begin
                        r_stage[i] <= Z3;
                    end
                end
            end

            if (w_frame_err) begin
                r_lock_cnt  <= LW'(1);
                r_locked    <= 1'b0;
                r_have_prev <= 1'b0;
            end else if (w_frame_ok) begin
                r_lock_cnt <= w_lock_inc;
                r_locked   <= (w_lock_inc == LW'(LOCK_WORDS));
            end

            if (w_last) begin
                r_sector <= r_stage;
                r_index  <= Z3;
                if (r_locked) begin
                    r_have_prev <= 1'b1;
                end
            end

            // A new match wins over the clearing word_end so back-to-back matches keep the window open.
            if (w_match) begin
                r_window <= 1'b1;
            end else if (w_last) begin
                r_window <= 1'b0;
            end
        end
    end

    assign bit_cnt  = r_bit_cnt;
    assign sector   = r_sector;
    assign index    = r_index;
    assign word_end = r_word_end;
    assign locked   = r_locked;
    assign match    = r_match;
    assign window   = r_window;
    assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_drum_sector_reader.sv
// Directed bench for drum_sector_reader: a track generator drives Z1/Z2/Z3 word
// by word and hand-computed per-word expectations are checked after each word.
module tb_drum_sector_reader;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       Z1 = 1'b0;
    logic       Z2 = 1'b0;
    logic       Z3 = 1'b0;
    logic [6:0] target = 7'd5;
    logic [5:0] bit_cnt;
    logic [6:0] sector;
    logic       index;
    logic       word_end;
    logic       locked;
    logic       match;
    logic       window;
    logic       seq_err;

    int n_checks = 0;
    int n_pass   = 0;
    int we_w     = 0;
    int match_w  = 0;
    int err_w    = 0;
    int win_cnt  = 0;

    drum_sector_reader dut (
        .CLK(CLK), .CLR(CLR), .Z1(Z1), .Z2(Z2), .Z3(Z3), .target(target),
        .bit_cnt(bit_cnt), .sector(sector), .index(index), .word_end(word_end),
        .locked(locked), .match(match), .window(window), .seq_err(seq_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock; outputs sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (word_end) we_w++;
        if (match) match_w++;
        if (seq_err) err_w++;
        if (window) win_cnt++;
    endtask

    task automatic send_bit(input logic strobe, input logic z2, input logic z3);
        Z1 = strobe;
        Z2 = z2;
        Z3 = z3;
        tick();
        Z1 = 1'b0;
        tick();
    endtask

    // Generates bits first_b..last_b of one drum word; drop_b suppresses one strobe.
    task automatic send_word(input int addr, input logic idx, input int first_b,
                             input int last_b, input int drop_b);
        logic [6:0] a;
        logic       z2;
        logic       z3;
        a       = addr[6:0];
        we_w    = 0;
        match_w = 0;
        err_w   = 0;
        for (int b = first_b; b <= last_b; b++) begin
            z2 = ((b >= 31) && (b <= 33)) || (b >= 38);
            if ((b >= 32) && (b <= 38)) z3 = a[b-32];
            else if (b == 39) z3 = idx;
            else z3 = 1'b0;
            send_bit(b != drop_b, z2, z3);
        end
    endtask

    task automatic word_check(input int addr, input logic exp_idx, input int exp_err,
                              input int exp_match, input logic exp_locked);
        check($sformatf("w%0d_word_end", addr), we_w, 1);
        check($sformatf("w%0d_sector", addr), sector, addr);
        check($sformatf("w%0d_index", addr), index, exp_idx);
        check($sformatf("w%0d_seq_err", addr), err_w, exp_err);
        check($sformatf("w%0d_match", addr), match_w, exp_match);
        check($sformatf("w%0d_locked", addr), locked, exp_locked);
    endtask

    task automatic reset_check(input string pfx);
        check({pfx, "_bit_cnt"}, bit_cnt, 0);
        check({pfx, "_sector"}, sector, 0);
        check({pfx, "_index"}, index, 0);
        check({pfx, "_word_end"}, word_end, 0);
        check({pfx, "_locked"}, locked, 0);
        check({pfx, "_match"}, match, 0);
        check({pfx, "_window"}, window, 0);
        check({pfx, "_seq_err"}, seq_err, 0);
    endtask

    initial begin
        repeat (4) tick();
        reset_check("rst");
        CLR = 1'b1;

        // Join mid-word: first sync is misaligned, second sync locks.
        send_word(120, 1'b0, 10, 39, -1);
        word_check(120, 1'b0, 1, 0, 1'b0);
        send_word(121, 1'b0, 0, 39, -1);
        word_check(121, 1'b0, 0, 0, 1'b1);

        // Nominal stream through the 127 -> 0 wrap.
        for (int a = 122; a <= 127; a++) begin
            send_word(a, 1'b0, 0, 39, -1);
            word_check(a, 1'b0, 0, 0, 1'b1);
        end
        send_word(0, 1'b1, 0, 39, -1);
        word_check(0, 1'b1, 0, 0, 1'b1);
        send_word(1, 1'b0, 0, 39, -1);
        word_check(1, 1'b0, 0, 0, 1'b1);
        send_word(2, 1'b0, 0, 39, -1);
        word_check(2, 1'b0, 0, 0, 1'b1);

        // Bad index flag on a non-zero address.
        send_word(3, 1'b1, 0, 39, -1);
        word_check(3, 1'b1, 1, 0, 1'b1);
        send_word(4, 1'b0, 0, 39, -1);
        word_check(4, 1'b0, 0, 0, 1'b1);

        // Match on target 5; window spans exactly one word (80 clocks).
        win_cnt = 0;
        send_word(5, 1'b0, 0, 39, -1);
        word_check(5, 1'b0, 0, 1, 1'b1);
        check("w5_window_hi", window, 1);
        send_word(6, 1'b0, 0, 39, -1);
        word_check(6, 1'b0, 0, 0, 1'b1);
        check("w6_window_lo", window, 0);
        check("win5_clocks", win_cnt, 80);

        // Target change across two words keeps the window continuous.
        win_cnt = 0;
        target  = 7'd7;
        send_word(7, 1'b0, 0, 39, -1);
        word_check(7, 1'b0, 0, 1, 1'b1);
        target  = 7'd8;
        send_word(8, 1'b0, 0, 39, -1);
        word_check(8, 1'b0, 0, 1, 1'b1);
        send_word(9, 1'b0, 0, 39, -1);
        word_check(9, 1'b0, 0, 0, 1'b1);
        check("win78_clocks", win_cnt, 160);

        // Address skip 10 -> 12 flags but keeps lock.
        send_word(10, 1'b0, 0, 39, -1);
        word_check(10, 1'b0, 0, 0, 1'b1);
        send_word(12, 1'b0, 0, 39, -1);
        word_check(12, 1'b0, 1, 0, 1'b1);
        send_word(13, 1'b0, 0, 39, -1);
        word_check(13, 1'b0, 0, 0, 1'b1);

        // Dropped strobe: error at the next sync, resync, relock next word.
        send_word(14, 1'b0, 0, 39, 5);
        word_check(14, 1'b0, 1, 0, 1'b0);
        check("w14_bit_cnt", bit_cnt, 39);
        send_word(15, 1'b0, 0, 39, -1);
        word_check(15, 1'b0, 0, 0, 1'b1);
        send_word(16, 1'b0, 0, 39, -1);
        word_check(16, 1'b0, 0, 0, 1'b1);

        // Reset in the middle of a word, then recover.
        send_word(17, 1'b0, 0, 35, -1);
        CLR = 1'b0;
        repeat (4) tick();
        reset_check("midrst");
        CLR = 1'b1;
        send_word(18, 1'b0, 0, 39, -1);
        word_check(18, 1'b0, 1, 0, 1'b0);
        send_word(19, 1'b0, 0, 39, -1);
        word_check(19, 1'b0, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
